// File: rtl/unidade_controle.sv
// unidade_controle: Moore control FSM for the memory-game datapath.
// Sequences one round of up to 16 plays, enforces a per-play response
// timeout and reports the result plus its own state code for debug.
module unidade_controle #(
    parameter int TIMEOUT = 3000,
    parameter int TW      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_TIMEOUT = 4'hC,
        FIM_ERROU   = 4'hE
    } estado_t;

    // Last count value spent in espera before giving up on the play.
    localparam logic [TW-1:0] LIM = TW'(TIMEOUT - 1);

    estado_t       r_estado;
    estado_t       w_prox;
    logic [TW-1:0] r_cnt;
    logic          w_fim_tempo;

    assign w_fim_tempo = (r_cnt == LIM);

    // State register; reset overrides every input.
    always_ff @(posedge clock) begin
        if (reset) r_estado <= INICIAL;
        else       r_estado <= w_prox;
    end

    // Timeout counter: runs only while the FSM lingers in espera, so it is
    // already zero on every fresh entry into espera.
    always_ff @(posedge clock) begin
        if (reset)
            r_cnt <= '0;
        else if (r_estado == ESPERA && w_prox == ESPERA)
            r_cnt <= r_cnt + TW'(1);
        else
            r_cnt <= '0;
    end

    // Next-state logic; a play beats a coincident timeout.
    always_comb begin
        w_prox = INICIAL;
        case (r_estado)
            INICIAL:     w_prox = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  w_prox = ESPERA;
            ESPERA: begin
                if (jogada_feita)     w_prox = REGISTRA;
                else if (w_fim_tempo) w_prox = FIM_TIMEOUT;
                else                  w_prox = ESPERA;
            end
            REGISTRA:    w_prox = COMPARACAO;
            COMPARACAO: begin
                if (!igual)    w_prox = FIM_ERROU;
                else if (fimC) w_prox = FIM_ACERTOU;
                else           w_prox = PROXIMO;
            end
            PROXIMO:     w_prox = ESPERA;
            FIM_ACERTOU: w_prox = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:   w_prox = iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT: w_prox = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:     w_prox = INICIAL;
        endcase
    end

    // Moore output decode from the registered state only.
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (r_estado)
            PREPARACAO:  begin zeraC = 1'b1; zeraR = 1'b1; end
            REGISTRA:    registraR = 1'b1;
            PROXIMO:     contaC = 1'b1;
            FIM_ACERTOU: begin pronto = 1'b1; acertou = 1'b1; end
            FIM_ERROU:   begin pronto = 1'b1; errou = 1'b1; end
            FIM_TIMEOUT: begin pronto = 1'b1; timeout = 1'b1; end
            default:     ;
        endcase
    end

    assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed testbench for unidade_controle (TIMEOUT = 8).
module tb_unidade_controle;

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada_feita, igual, fimC;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    unidade_controle #(.TIMEOUT(8), .TW(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .igual(igual), .fimC(fimC),
        .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Advance one edge; inputs are driven and outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start from inicial or a fim_* state, ending in the first espera cycle.
    task automatic start_round();
        iniciar = 1'b1; tick();
        iniciar = 1'b0; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; tick();
        checks++;
        if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_state got %h want 0", db_estado); end
        reset = 1'b0;
        // jogada_feita is ignored in inicial
        jogada_feita = 1'b1; tick();
        jogada_feita = 1'b0;
        checks++;
        if (db_estado !== 4'h0 || registraR !== 1'b0) begin
            errors++; $display("FAIL ignore_jogada_inicial got %h/%b want 0/0", db_estado, registraR);
        end
        iniciar = 1'b1; tick();
        checks++;
        if (db_estado !== 4'h1 || zeraC !== 1'b1 || zeraR !== 1'b1) begin
            errors++; $display("FAIL start_prep got %h zc%b zr%b want 1 1 1", db_estado, zeraC, zeraR);
        end
        iniciar = 1'b0; tick();
        checks++;
        if (db_estado !== 4'h2) begin errors++; $display("FAIL start_espera got %h want 2", db_estado); end
        jogada_feita = 1'b1; igual = 1'b1; tick();
        jogada_feita = 1'b0;
        checks++;
        if (db_estado !== 4'h4 || registraR !== 1'b1) begin
            errors++; $display("FAIL registra got %h/%b want 4/1", db_estado, registraR);
        end
        // two-cycle reset while in registra
        reset = 1'b1; tick();
        checks++;
        if ({db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout} !== 12'h000) begin
            errors++; $display("FAIL reset_mid_round got %h want 0 with outputs 0", db_estado);
        end
        iniciar = 1'b1; tick();
        checks++;
        if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_priority got %h want 0", db_estado); end
        reset = 1'b0; iniciar = 1'b0;
    endtask

    task automatic test_full_round();
        int pulses = 0;
        start_round();
        for (int i = 1; i <= 16; i++) begin
            jogada_feita = 1'b1; igual = 1'b1; fimC = (i == 16); tick();
            jogada_feita = 1'b0; tick();               // comparacao
            if (i == 2) jogada_feita = 1'b1;           // pulse in comparacao must be ignored
            tick();
            jogada_feita = 1'b0;
            if (contaC) pulses++;
            if (i < 16) tick();                        // back to espera
        end
        fimC = 1'b0;
        checks++;
        if (pulses != 15) begin errors++; $display("FAIL full_contaC got %0d want 15", pulses); end
        checks++;
        if (db_estado !== 4'hA || pronto !== 1'b1 || acertou !== 1'b1 || errou !== 1'b0) begin
            errors++; $display("FAIL full_result got %h p%b a%b e%b want A 1 1 0", db_estado, pronto, acertou, errou);
        end
        tick(); tick(); tick();
        checks++;
        if (db_estado !== 4'hA || acertou !== 1'b1) begin
            errors++; $display("FAIL full_hold got %h/%b want A/1", db_estado, acertou);
        end
    endtask

    task automatic test_wrong_play();
        int pulses = 0;
        start_round();
        for (int i = 1; i <= 3; i++) begin
            jogada_feita = 1'b1; igual = (i != 3); tick();
            jogada_feita = 1'b0; tick(); tick();
            if (contaC) pulses++;
            if (i < 3) tick();
        end
        igual = 1'b1;
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL wrong_contaC got %0d want 2", pulses); end
        checks++;
        if (db_estado !== 4'hE || errou !== 1'b1 || pronto !== 1'b1 || acertou !== 1'b0) begin
            errors++; $display("FAIL wrong_result got %h e%b p%b a%b want E 1 1 0", db_estado, errou, pronto, acertou);
        end
    endtask

    task automatic test_restart();
        iniciar = 1'b1; tick();
        checks++;
        if (db_estado !== 4'h1 || zeraC !== 1'b1 || zeraR !== 1'b1 || pronto !== 1'b0 || errou !== 1'b0) begin
            errors++; $display("FAIL restart_prep got %h zc%b zr%b p%b e%b want 1 1 1 0 0", db_estado, zeraC, zeraR, pronto, errou);
        end
        iniciar = 1'b0; tick();
        checks++;
        if (db_estado !== 4'h2 || zeraC !== 1'b0 || zeraR !== 1'b0) begin
            errors++; $display("FAIL restart_espera got %h zc%b zr%b want 2 0 0", db_estado, zeraC, zeraR);
        end
    endtask

    // Entered with the FSM in its first espera cycle.
    task automatic test_timeout();
        for (int t = 1; t <= 7; t++) tick();
        checks++;
        if (db_estado !== 4'h2) begin errors++; $display("FAIL timeout_early got %h want 2", db_estado); end
        tick();
        checks++;
        if (db_estado !== 4'hC || timeout !== 1'b1 || pronto !== 1'b1) begin
            errors++; $display("FAIL timeout_entry got %h t%b p%b want C 1 1", db_estado, timeout, pronto);
        end
        start_round();
        for (int t = 1; t <= 7; t++) tick();
        jogada_feita = 1'b1; tick();
        jogada_feita = 1'b0;
        checks++;
        if (db_estado !== 4'h4 || registraR !== 1'b1 || timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_play_wins got %h r%b t%b want 4 1 0", db_estado, registraR, timeout);
        end
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b1; fimC = 1'b0;
        #2;
        test_reset();
        test_full_round();
        test_wrong_play();
        test_restart();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Moore control FSM for the memory-game datapath. It sits directly upstream of the datapath and drives its counter-clear, counter-enable, register-clear and register-enable controls. It consumes the datapath's `igual`, `fimC` and `jogada_feita` status lines and sequences one round of up to 16 plays. It also enforces a per-play response timeout and reports the game result and its own state for debug.

## Interface
Parameters:
- `TIMEOUT`, default 3000: cycles allowed in the wait state before timeout; must be ≥2.
- `TW`, default 16: timeout counter width; must satisfy `TIMEOUT` ≤ 2^`TW`.

Ports:
- `clock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high; forces `inicial`.
- `iniciar` in 1: start request, level-sampled.
- `jogada_feita` in 1: one-cycle pulse from the datapath edge detector.
- `igual` in 1: datapath comparator equal (ROM data == registered play).
- `fimC` in 1: datapath address counter at terminal count (address 15).
- `zeraC` out 1: clear address counter.
- `contaC` out 1: increment address counter.
- `zeraR` out 1: clear play register.
- `registraR` out 1: load play register.
- `pronto` out 1: round finished.
- `acertou` out 1: all 16 plays correct.
- `errou` out 1: wrong play.
- `timeout` out 1: no play within `TIMEOUT` cycles.
- `db_estado` out 4: current state code.

## Operation
- All outputs are registered-state decodes (Moore); none depends combinationally on inputs.
- States, codes and asserted outputs:
  - `inicial` (0x0): none.
  - `preparacao` (0x1): `zeraC`, `zeraR`.
  - `espera` (0x2): none.
  - `registra` (0x4): `registraR`.
  - `comparacao` (0x5): none.
  - `proximo` (0x6): `contaC`.
  - `fim_acertou` (0xA): `pronto`, `acertou`.
  - `fim_errou` (0xE): `pronto`, `errou`.
  - `fim_timeout` (0xC): `pronto`, `timeout`.
- Transitions:
  - `inicial`: `iniciar`=1 → `preparacao`; otherwise stay.
  - `preparacao` → `espera`, unconditionally.
  - `espera`: `jogada_feita`=1 → `registra`. Else, if the timeout count equals `TIMEOUT`−1 → `fim_timeout`. Else stay.
  - `registra` → `comparacao`, unconditionally.
  - `comparacao`: `igual`=0 → `fim_errou`. Else `fimC`=1 → `fim_acertou`. Else → `proximo`.
  - `proximo` → `espera`.
  - Any `fim_*` state: `iniciar`=1 → `preparacao`; otherwise hold with result outputs stable.
- Timeout counter (`TW` bits):
  - Zero in every state other than `espera`.
  - Increments by 1 on each `espera` cycle in which it stays in `espera`.
  - Never wraps, since it exits at `TIMEOUT`−1.
- Unused state encodings → `inicial` on the next edge, with all outputs 0.

## Timing
- Reset, whether asserted mid-round or in any state:
  - Next edge: state `inicial`, timeout counter 0.
  - All control and result outputs 0; `db_estado`=0x0.
  - `reset` has priority over every input.
- Start: `iniciar` sampled high in `inicial` at edge k gives `preparacao` in cycle k+1 and `espera` in cycle k+2.
- Play handling: `jogada_feita` high in `espera` at edge k gives:
  - `registraR` high during cycle k+1;
  - comparison in cycle k+2 (register output is valid then);
  - `proximo` or `fim_*` entered at k+3.
- Play-to-play: `contaC` is high for exactly one cycle per correct non-final play. The counter advances at the edge leaving `proximo`, so the new ROM data is valid by the next `comparacao`.
- Timeout priority: if `jogada_feita` and the terminal timeout count coincide, the play wins (→ `registra`).
- Timeout latency: with no play, `fim_timeout` is entered exactly `TIMEOUT` cycles after entering `espera`.
- Ignored inputs: `jogada_feita` outside `espera` and `iniciar` outside `inicial`/`fim_*`.
- No outputs glitch between states; each state's outputs change only at clock edges.

## Test plan
- **Reset:** assert `reset` 2 cycles during `registra` → `db_estado`=0x0 and all outputs 0 on the next edge; `iniciar` pulse → 0x1 then 0x2.
- **Full correct round:** `igual`=1 for all plays, `fimC`=1 only on play 16 → exactly 15 `contaC` pulses; after play 16, `pronto`=`acertou`=1 and `db_estado`=0xA held until `iniciar`.
- **Wrong play:** `igual`=0 on play 3 → 2 `contaC` pulses total; `errou`=`pronto`=1, `db_estado`=0xE, `acertou`=0.
- **Timeout:** `TIMEOUT`=8, no play → `fim_timeout` (0xC) entered exactly 8 cycles after entering `espera`, with `timeout`=1. A play on cycle 7 instead → `registra`.
- **Restart:** from `fim_errou`, pulse `iniciar` → `zeraC`=`zeraR`=1 for one cycle, results cleared, back in `espera`.
- **Ignored pulses:** `jogada_feita` pulsed in `inicial` and `comparacao` → no state deviation, `registraR` not asserted.
